// File: rtl/demux_regbank_8x16_pkg.sv
// Shared constants and clear-FSM encoding for the 8x16 write-side register bank.
package demux_regbank_8x16_pkg;

  localparam int REG_W = 16;
  localparam int REG_N = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/demux_regbank_8x16_decode.sv
// 3-to-8 one-hot write-enable decoder, gated by a single enable.
module regwrite_decode_3to8
  import demux_regbank_8x16_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [REG_N-1:0] we_o
);

  always_comb begin
    we_o = '0;
    if (en_i) begin
      we_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_regbank_8x16.sv
// Write side of the 8-entry register bank: one-stage staged write, parallel
// register outputs, pending-write forwarding taps and a one-per-cycle clear sweep.
module demux_regbank_8x16
  import demux_regbank_8x16_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NREG    = 8,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] D,
  output logic             ready,
  input  logic             clr,
  output logic             busy,
  output logic             clr_done,
  output logic             pend_v,
  output logic [2:0]       pend_s,
  output logic [WIDTH-1:0] pend_d,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic [WIDTH-1:0] O5,
  output logic [WIDTH-1:0] O6,
  output logic [WIDTH-1:0] O7
);

  state_e             state_q;
  logic [IDX_W-1:0]   cnt_q;
  logic               clr_done_q;
  logic               pend_v_q;
  logic [IDX_W-1:0]   pend_s_q;
  logic [WIDTH-1:0]   pend_d_q;
  logic [WIDTH-1:0]   regs_q [NREG];

  logic [REG_N-1:0]   commit_we;
  logic [REG_N-1:0]   sweep_we;
  logic [REG_N-1:0]   commit_mask;
  logic               accept;

  assign ready  = (state_q == IDLE);
  assign busy   = (state_q == CLEAR);
  assign accept = E && ready;

  regwrite_decode_3to8 u_commit_dec (
    .idx_i (pend_s_q),
    .en_i  (pend_v_q),
    .we_o  (commit_we)
  );

  regwrite_decode_3to8 u_sweep_dec (
    .idx_i (cnt_q),
    .en_i  (busy),
    .we_o  (sweep_we)
  );

  // Register 0 may be hardwired: its commit is dropped, though the write still stages.
  assign commit_mask = ZERO_R0 ? {{(REG_N-1){1'b1}}, 1'b0} : {REG_N{1'b1}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_s_q   <= '0;
      pend_d_q   <= '0;
    end else begin
      clr_done_q <= 1'b0;
      pend_v_q   <= accept;
      if (accept) begin
        pend_s_q <= s;
        pend_d_q <= D;
      end
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          if (cnt_q == IDX_W'(NREG - 1)) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sweep beats a same-edge commit so the bank is all-zero when the sweep ends.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst || sweep_we[i]) begin
        regs_q[i] <= '0;
      end else if (commit_we[i] && commit_mask[i]) begin
        regs_q[i] <= pend_d_q;
      end
    end
  end

  assign clr_done = clr_done_q;
  assign pend_v   = pend_v_q;
  assign pend_s   = pend_s_q;
  assign pend_d   = pend_d_q;

  assign O0 = regs_q[0];
  assign O1 = regs_q[1];
  assign O2 = regs_q[2];
  assign O3 = regs_q[3];
  assign O4 = regs_q[4];
  assign O5 = regs_q[5];
  assign O6 = regs_q[6];
  assign O7 = regs_q[7];

endmodule

// File: tb/tb_demux_regbank_8x16.sv
// Bench for demux_regbank_8x16: directed scenarios plus randomized traffic
// checked against an array-based behavioural model of the bank.
module tb_demux_regbank_8x16;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, E, clr;
  logic [2:0]   s;
  logic [W-1:0] D;
  logic         ready, busy, clr_done, pend_v;
  logic [2:0]   pend_s;
  logic [W-1:0] pend_d;
  logic [W-1:0] O0, O1, O2, O3, O4, O5, O6, O7;
  logic [W-1:0] Ov [8];

  int n_chk = 0;
  int n_fail = 0;

  // behavioural model
  logic [W-1:0] m_regs [8];
  logic         m_pv;
  logic [2:0]   m_ps;
  logic [W-1:0] m_pd;
  bit           m_sweep;
  int           m_idx;
  bit           m_done;

  always #5 clk = ~clk;

  demux_regbank_8x16 #(.WIDTH(W), .NREG(8), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst(rst), .E(E), .s(s), .D(D), .ready(ready),
    .clr(clr), .busy(busy), .clr_done(clr_done),
    .pend_v(pend_v), .pend_s(pend_s), .pend_d(pend_d),
    .O0(O0), .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5), .O6(O6), .O7(O7)
  );

  assign Ov[0] = O0; assign Ov[1] = O1; assign Ov[2] = O2; assign Ov[3] = O3;
  assign Ov[4] = O4; assign Ov[5] = O5; assign Ov[6] = O6; assign Ov[7] = O7;

  // One clock edge: advance the model with the inputs seen at that edge, then settle.
  task automatic tick();
    bit was_sweep;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_pv = 0; m_ps = '0; m_pd = '0;
      m_sweep = 0; m_idx = 0; m_done = 0;
    end else begin
      was_sweep = m_sweep;
      if (m_pv && m_ps != 3'd0) m_regs[m_ps] = m_pd;
      if (was_sweep) m_regs[m_idx] = '0;
      m_pv = E && !was_sweep;
      if (m_pv) begin m_ps = s; m_pd = D; end
      m_done = was_sweep && (m_idx == 7);
      if (was_sweep) begin
        if (m_idx == 7) m_sweep = 0; else m_idx = m_idx + 1;
      end else if (clr) begin
        m_sweep = 1; m_idx = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; E = 0; clr = 0; s = '0; D = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (Ov[i] !== 16'h0000) begin
        n_fail++; $display("FAIL reset_O%0d got %h want 0000", i, Ov[i]);
      end
    end
    n_chk++;
    if ({pend_v, ready, busy, clr_done} !== 4'b0100) begin
      n_fail++; $display("FAIL reset_ctrl got pv/rdy/busy/done=%b want 0100", {pend_v, ready, busy, clr_done});
    end
  endtask

  task automatic test_single_write();
    E = 1; s = 3'd3; D = 16'hBEEF; tick(); E = 0;
    n_chk++;
    if ({pend_v, pend_s, pend_d} !== {1'b1, 3'd3, 16'hBEEF}) begin
      n_fail++; $display("FAIL single_stage got v=%b s=%0d d=%h want v=1 s=3 d=beef", pend_v, pend_s, pend_d);
    end
    n_chk++;
    if (O3 !== 16'h0000) begin
      n_fail++; $display("FAIL single_early got O3=%h want 0000", O3);
    end
    tick();
    n_chk++;
    if (O3 !== 16'hBEEF || pend_v !== 1'b0) begin
      n_fail++; $display("FAIL single_commit got O3=%h pv=%b want beef 0", O3, pend_v);
    end
  endtask

  task automatic test_back_to_back();
    E = 1; s = 3'd5; D = 16'h1111; tick();
    D = 16'h2222; tick(); E = 0;
    n_chk++;
    if (O5 !== 16'h1111) begin
      n_fail++; $display("FAIL b2b_first got O5=%h want 1111", O5);
    end
    tick();
    n_chk++;
    if (O5 !== 16'h2222) begin
      n_fail++; $display("FAIL b2b_last got O5=%h want 2222", O5);
    end
  endtask

  task automatic test_r0();
    E = 1; s = 3'd0; D = 16'hFFFF; tick(); E = 0;
    n_chk++;
    if (pend_v !== 1'b1 || pend_s !== 3'd0) begin
      n_fail++; $display("FAIL r0_stage got pv=%b ps=%0d want 1 0", pend_v, pend_s);
    end
    tick();
    n_chk++;
    if (O0 !== 16'h0000 || pend_v !== 1'b0) begin
      n_fail++; $display("FAIL r0_hold got O0=%h pv=%b want 0000 0", O0, pend_v);
    end
  endtask

  task automatic preload();
    for (int i = 1; i < 8; i++) begin
      E = 1; s = 3'(i); D = 16'h00A0 + 16'(i); tick();
    end
    E = 0; tick();
  endtask

  task automatic test_clear_concurrent();
    int pulses;
    preload();
    n_chk++;
    if (O1 !== 16'h00A1 || O7 !== 16'h00A7) begin
      n_fail++; $display("FAIL preload got O1=%h O7=%h want 00a1 00a7", O1, O7);
    end
    clr = 1; E = 1; s = 3'd6; D = 16'h7777; tick();
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
        n_fail++; $display("FAIL clr_busy k=%0d got busy=%b rdy=%b want 1 0", k, busy, ready);
      end
      if (k >= 1) begin
        n_chk++;
        if (pend_v !== 1'b0) begin
          n_fail++; $display("FAIL clr_drain k=%0d got pv=%b want 0", k, pend_v);
        end
      end
      if (k >= 1 && k <= 6) begin
        n_chk++;
        if (O6 !== 16'h7777) begin
          n_fail++; $display("FAIL clr_o6_commit k=%0d got O6=%h want 7777", k, O6);
        end
      end
      if (clr_done) pulses++;
      clr = 1'($urandom_range(0, 1)); E = 1'($urandom_range(0, 1));
      s = 3'($urandom_range(0, 7)); D = 16'($urandom);
      tick();
    end
    clr = 0; E = 0;
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (Ov[i] !== 16'h0000) begin
        n_fail++; $display("FAIL clr_end_O%0d got %h want 0000", i, Ov[i]);
      end
    end
    n_chk++;
    if (busy !== 1'b0 || ready !== 1'b1 || clr_done !== 1'b1 || pend_v !== 1'b0) begin
      n_fail++; $display("FAIL clr_end_ctrl got busy=%b rdy=%b done=%b pv=%b want 0 1 1 0", busy, ready, clr_done, pend_v);
    end
    tick();
    n_chk++;
    if (clr_done !== 1'b0 || pulses != 0) begin
      n_fail++; $display("FAIL clr_done_width got done=%b early_pulses=%0d want 0 0", clr_done, pulses);
    end
  endtask

  task automatic test_reset_mid_sweep();
    preload();
    clr = 1; tick(); clr = 0;
    for (int k = 0; k < 4; k++) tick();
    n_chk++;
    if (O3 !== 16'h0000 || O4 !== 16'h00A4 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_sweep got O3=%h O4=%h busy=%b want 0000 00a4 1", O3, O4, busy);
    end
    rst = 1; tick(); rst = 0;
    n_chk++;
    if (busy !== 1'b0 || ready !== 1'b1 || clr_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_sweep_ctrl got busy=%b rdy=%b done=%b want 0 1 0", busy, ready, clr_done);
    end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (Ov[i] !== 16'h0000) begin
        n_fail++; $display("FAIL rst_sweep_O%0d got %h want 0000", i, Ov[i]);
      end
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_chk++;
      if (clr_done !== 1'b0) begin
        n_fail++; $display("FAIL rst_sweep_nopulse k=%0d got done=%b want 0", k, clr_done);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 19) == 0);
      E = 1'($urandom_range(0, 3) != 0);
      s = 3'($urandom_range(0, 7));
      D = 16'($urandom);
      tick();
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (Ov[i] !== m_regs[i]) begin
          n_fail++; $display("FAIL rand_O%0d cyc=%0d got %h want %h", i, c, Ov[i], m_regs[i]);
        end
      end
      n_chk++;
      if (pend_v !== m_pv || (m_pv && (pend_s !== m_ps || pend_d !== m_pd))) begin
        n_fail++; $display("FAIL rand_pend cyc=%0d got %b/%0d/%h want %b/%0d/%h", c, pend_v, pend_s, pend_d, m_pv, m_ps, m_pd);
      end
      n_chk++;
      if (busy !== m_sweep || ready !== !m_sweep || clr_done !== m_done) begin
        n_fail++; $display("FAIL rand_ctrl cyc=%0d got busy=%b rdy=%b done=%b want %b %b %b", c, busy, ready, clr_done, m_sweep, !m_sweep, m_done);
      end
    end
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_pv = 0; m_ps = '0; m_pd = '0; m_sweep = 0; m_idx = 0; m_done = 0;
    #2;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_r0();
    test_clear_concurrent();
    test_reset_mid_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_regbank_8x16.md
Name: demux_regbank_8x16

Overview:
Write side of the 8-entry, 16-bit register bank read by the datapath's 8:1 read muxes.
- Accepts one write request per cycle (data, 3-bit destination, enable) and demultiplexes it through a one-stage write pipeline into one of 8 registers.
- Exposes all 8 register values as parallel outputs for the read-side muxes, plus the in-flight write for forwarding.
- Provides a sequenced clear operation that sweeps all registers to zero, one per cycle.

Parameters:
WIDTH, 16, data width of each register
NREG, 8, number of registers; fixed at 8 (3-bit select)
ZERO_R0, 1, 1 = register 0 hardwired to zero (writes to it discarded); 0 = register 0 writable

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
E  in  1  write request valid
s  in  3  write destination register index
D  in  WIDTH  write data
ready  out  1  write request accepted on the edge when E && ready
clr  in  1  start clear sweep (sampled in IDLE only)
busy  out  1  clear sweep in progress
clr_done  out  1  one-cycle pulse after the final register is cleared
pend_v  out  1  stage register holds a write not yet committed
pend_s  out  3  destination of the pending write
pend_d  out  WIDTH  data of the pending write
O0..O7  out  WIDTH each  current register contents

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. On the rst edge:
  - O0..O7 = 0, pend_v = 0, pend_s = 0, pend_d = 0.
  - state = IDLE, sweep counter = 0, clr_done = 0.
  - rst has priority over every other input, including mid-sweep and pending writes; the pending write is dropped.
- ready = (state == IDLE), combinational; busy = (state == CLEAR).
- Write pipeline:
  - Accept edge: if E && ready, the stage captures pend_v = 1, pend_s = s, pend_d = D. Otherwise pend_v = 0.
  - Commit edge (next edge): if pend_v, register[pend_s] = pend_d.
  - Latency is 2 edges from request to visibility on O[s]. Back-to-back writes every cycle are sustained.
  - Consecutive writes to the same index commit in order; the last one wins.
  - Forwarding is the reader's job via pend_v/pend_s/pend_d; this block does not bypass internally.
- ZERO_R0 = 1: writes to index 0 are accepted and staged (pend_v = 1) but the commit is discarded; O0 is constant 0.
- Decode: the commit write-enable is a one-hot of pend_s, gated by pend_v.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on an edge with clr = 1; cnt = 0. A write accepted on that same edge is still staged.
  - In CLEAR, each edge: register[cnt] = 0, cnt = cnt + 1.
  - At cnt == NREG-1: register 7 is cleared, state -> IDLE, and clr_done = 1 for exactly the next cycle.
  - The sweep takes NREG = 8 cycles. clr is ignored while in CLEAR.
  - Same-edge conflict: if the stage commit and the sweep target the same register on one edge, the sweep wins (register = 0).
  - A commit to a higher index than cnt is later overwritten by the sweep, so every register is 0 when the sweep ends.
  - E is not accepted in CLEAR (ready = 0); the stage drains to pend_v = 0 after the first CLEAR edge.
- Register values O0..O7 are held indefinitely absent a commit, sweep or reset.

Decomposition:
- Shared package:
  - WIDTH and NREG constants.
  - FSM state encoding: IDLE = 1'b0, CLEAR = 1'b1.
  - Index width constant: 3.
- One natural sub-module: regwrite_decode_3to8. Maps a 3-bit index plus enable to 8 one-hot write enables. Instantiated twice: once for the commit enable, once for the sweep enable.
- The top level combines the two enable sets with sweep priority.

Test Plan:
- Reset then idle: assert rst 1 cycle -> O0..O7 = 0x0000, pend_v = 0, ready = 1, busy = 0.
- Single write: E = 1, s = 3, D = 0xBEEF for 1 cycle -> the next cycle shows pend_v = 1, pend_s = 3, pend_d = 0xBEEF; the cycle after shows O3 = 0xBEEF and pend_v = 0.
- Back-to-back same index: E high 2 cycles, s = 5, D = 0x1111 then 0x2222 -> O5 = 0x1111 then 0x2222 on consecutive cycles.
- R0 hardwiring (ZERO_R0 = 1): E = 1, s = 0, D = 0xFFFF -> pend_v = 1 for one cycle; O0 stays 0x0000.
- Clear with concurrent write: preload O1..O7 = 0x00A1..0x00A7, then assert clr = 1 together with E = 1, s = 6, D = 0x7777:
  - busy = 1 and ready = 0 for 8 cycles.
  - O6 = 0x7777 briefly, then 0.
  - All O = 0 at the end; clr_done pulses once.
- Reset mid-sweep: assert rst at cnt = 4 -> the next cycle shows state IDLE, busy = 0, all O = 0, and clr_done never pulses.
